// File: rtl/ddos_rate_table_if.sv
// Request/result bus between the header parser/hash unit and the rate table.
// The master drives requests and receives one result strobe per accepted request.
interface ddos_rate_table_if #(
  parameter int KEY_W  = 32,
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 10
);
  logic              req_vld;
  logic              req_rdy;
  logic [KEY_W-1:0]  req_key;
  logic [ADDR_W-1:0] req_idx;
  logic              res_vld;
  logic              res_drop;
  logic [KEY_W-1:0]  res_key;
  logic [CNT_W-1:0]  res_cnt;

  modport master (
    output req_vld, req_key, req_idx,
    input  req_rdy, res_vld, res_drop, res_key, res_cnt
  );

  modport slave (
    input  req_vld, req_key, req_idx,
    output req_rdy, res_vld, res_drop, res_key, res_cnt
  );
endinterface

// File: rtl/ddos_rate_table.sv
// Set-associative per-source packet rate table with drop verdicts and a
// periodic window flush. One request is processed every three clocks.
//
// state  | meaning
// -------+-------------------------------------------------------------
// CLEAR  | post-reset sweep writing every set invalid, one set per cycle
// IDLE   | ready for a request unless a flush is pending
// READ   | set index presented to the way RAMs
// UPDATE | ways compared, write-back and result registered at cycle end
// FLUSH  | window-expiry sweep, identical to CLEAR
module ddos_rate_table #(
  parameter int KEY_W  = 32,
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 10,
  parameter int WAYS   = 2
) (
  input  logic              clk,
  input  logic              reset,
  ddos_rate_table_if.slave  bus,
  input  logic [CNT_W-1:0]  threshold_i,
  input  logic [31:0]       window_cycles_i,
  output logic              flush_busy_o,
  output logic [31:0]       drop_total_o,
  output logic [31:0]       evict_total_o,
  output logic [31:0]       nostore_total_o
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int ENT_W = 1 + KEY_W + CNT_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_READ, S_UPDATE, S_FLUSH} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q;
  logic [KEY_W-1:0]  key_q;
  logic [ADDR_W-1:0] set_q;
  logic [31:0]       timer_q;
  logic              flush_pend_q;
  logic              res_vld_q, res_drop_q;
  logic [KEY_W-1:0]  res_key_q;
  logic [CNT_W-1:0]  res_cnt_q;
  logic [31:0]       drop_q, evict_q, nostore_q;

  // entry layout: {vld, key, cnt}
  logic [ENT_W-1:0]  mem_q [WAYS][DEPTH];
  logic [ENT_W-1:0]  rd_q  [WAYS];

  logic              sweeping, sweep_last, req_rdy, accept, flush_start;
  logic              hit, free;
  logic [WAY_W-1:0]  hit_way, free_way, vict_way;
  logic [CNT_W-1:0]  hit_cnt, vict_cnt;
  logic              wr_en;
  logic [WAY_W-1:0]  wr_way;
  logic [CNT_W-1:0]  wr_cnt;
  logic              res_drop_d;
  logic [CNT_W-1:0]  res_cnt_d;
  logic              inc_drop, inc_evict, inc_nostore;

  assign sweeping    = (state_q == S_CLEAR) || (state_q == S_FLUSH);
  assign sweep_last  = (sweep_q == {ADDR_W{1'b1}});
  assign req_rdy     = (state_q == S_IDLE) && !flush_pend_q;
  assign accept      = bus.req_vld && req_rdy;
  assign flush_start = (state_q == S_IDLE) && flush_pend_q;

  // next-state logic; a pending flush takes priority over new requests
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR, S_FLUSH: if (sweep_last) state_d = S_IDLE;
      S_IDLE: begin
        if (flush_pend_q)     state_d = S_FLUSH;
        else if (bus.req_vld) state_d = S_READ;
      end
      S_READ:   state_d = S_UPDATE;
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_CLEAR;
    endcase
  end

  // way compare: lowest matching way, lowest free way, min-count victim (lowest on tie)
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    hit_cnt  = '0;
    free     = 1'b0;
    free_way = '0;
    vict_way = '0;
    vict_cnt = rd_q[0][CNT_W-1:0];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (rd_q[w][ENT_W-1] && (rd_q[w][CNT_W +: KEY_W] == key_q)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
        hit_cnt = rd_q[w][CNT_W-1:0];
      end
      if (!rd_q[w][ENT_W-1]) begin
        free     = 1'b1;
        free_way = WAY_W'(w);
      end
    end
    for (int w = 1; w < WAYS; w++) begin
      if (rd_q[w][CNT_W-1:0] < vict_cnt) begin
        vict_cnt = rd_q[w][CNT_W-1:0];
        vict_way = WAY_W'(w);
      end
    end
  end

  // verdict and write-back decision; victims with a tiny or already-abusive count are replaceable
  always_comb begin
    wr_en       = 1'b0;
    wr_way      = '0;
    wr_cnt      = '0;
    res_drop_d  = 1'b0;
    res_cnt_d   = '0;
    inc_drop    = 1'b0;
    inc_evict   = 1'b0;
    inc_nostore = 1'b0;
    if (hit) begin
      if (hit_cnt >= threshold_i) begin
        res_drop_d = 1'b1;
        res_cnt_d  = hit_cnt;
        inc_drop   = 1'b1;
      end else begin
        wr_en     = 1'b1;
        wr_way    = hit_way;
        wr_cnt    = (hit_cnt == CNT_MAX) ? CNT_MAX : hit_cnt + CNT_ONE;
        res_cnt_d = wr_cnt;
      end
    end else if (free) begin
      wr_en     = 1'b1;
      wr_way    = free_way;
      wr_cnt    = CNT_ONE;
      res_cnt_d = CNT_ONE;
    end else if ((vict_cnt <= CNT_ONE) || (vict_cnt >= threshold_i)) begin
      wr_en     = 1'b1;
      wr_way    = vict_way;
      wr_cnt    = CNT_ONE;
      res_cnt_d = CNT_ONE;
      inc_evict = 1'b1;
    end else begin
      inc_nostore = 1'b1;
    end
  end

  // way RAMs: sweep invalidates a set per cycle, UPDATE writes one way, READ fetches all ways
  always_ff @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (!reset && sweeping)
        mem_q[w][sweep_q] <= '0;
      else if (!reset && (state_q == S_UPDATE) && wr_en && (wr_way == WAY_W'(w)))
        mem_q[w][set_q] <= {1'b1, key_q, wr_cnt};
      if (state_q == S_READ)
        rd_q[w] <= mem_q[w][set_q];
    end
  end

  // state, request latch, result registers and saturating statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_CLEAR;
      sweep_q    <= '0;
      key_q      <= '0;
      set_q      <= '0;
      res_vld_q  <= 1'b0;
      res_drop_q <= 1'b0;
      res_key_q  <= '0;
      res_cnt_q  <= '0;
      drop_q     <= '0;
      evict_q    <= '0;
      nostore_q  <= '0;
    end else begin
      state_q <= state_d;
      if (sweeping)    sweep_q <= sweep_q + ADDR_W'(1);
      if (flush_start) sweep_q <= '0;
      if (accept) begin
        key_q <= bus.req_key;
        set_q <= bus.req_idx;
      end
      res_vld_q <= (state_q == S_UPDATE);
      if (state_q == S_UPDATE) begin
        res_drop_q <= res_drop_d;
        res_key_q  <= key_q;
        res_cnt_q  <= res_cnt_d;
        if (inc_drop && (drop_q != 32'hFFFF_FFFF))       drop_q    <= drop_q + 32'd1;
        if (inc_evict && (evict_q != 32'hFFFF_FFFF))     evict_q   <= evict_q + 32'd1;
        if (inc_nostore && (nostore_q != 32'hFFFF_FFFF)) nostore_q <= nostore_q + 32'd1;
      end
    end
  end

  // window timer; raises a flush request at each window end, dropped as the flush starts
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      if (flush_start) flush_pend_q <= 1'b0;
      if (state_q != S_CLEAR) begin
        if (window_cycles_i == 32'd0) begin
          timer_q <= '0;
        end else if (timer_q == window_cycles_i - 32'd1) begin
          timer_q      <= '0;
          flush_pend_q <= 1'b1;
        end else begin
          timer_q <= timer_q + 32'd1;
        end
      end
    end
  end

  assign bus.req_rdy      = req_rdy;
  assign bus.res_vld      = res_vld_q;
  assign bus.res_drop     = res_drop_q;
  assign bus.res_key      = res_key_q;
  assign bus.res_cnt      = res_cnt_q;
  assign flush_busy_o     = sweeping;
  assign drop_total_o     = drop_q;
  assign evict_total_o    = evict_q;
  assign nostore_total_o  = nostore_q;
endmodule
